fetch_unit: RTL

Program-counter and instruction-fetch stage of the PUC CPU. It sits directly upstream of the combinational instruction memory: it drives `pc`, samples the returned `instruction` in the same cycle, and hands `{pc, instruction}` pairs to decode through a 2-entry valid/ready buffer. It supports redirects (jump/branch) with flush, halt/resume, and wrap-around at the end of the program image.

---
 rtl/puc_pkg.sv | 13 +
 rtl/fetch_buffer.sv | 57 +++++
 rtl/fetch_unit.sv | 85 ++++++++
 3 files changed

// File: rtl/puc_pkg.sv
// Shared types and program-image constants for the PUC CPU.
// Fetch and instruction memory both use these bounds, so they wrap at the same address.
package puc_pkg;
    localparam int PC_WIDTH          = 8;
    localparam int INSTRUCTION_WIDTH = 16;
    localparam int RESET_PC          = 0;
    localparam int LAST_PC           = 11;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;
endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO between fetch and decode.
// The head comes straight from a register, and any empty slot is held at zero.
module fetch_buffer #(
    parameter int WIDTH = 24
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] data,
    output logic             valid,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       count
);
    logic [WIDTH-1:0] slot0, slot1;
    logic [WIDTH-1:0] slot0_next, slot1_next;
    logic [1:0]       count_next;

    // The pop is applied first, so a push in the same cycle lands in the freed slot.
    always_comb begin
        slot0_next = slot0;
        slot1_next = slot1;
        count_next = count;
        if (flush) begin
            slot0_next = '0;
            slot1_next = '0;
            count_next = 2'd0;
        end else begin
            if (pop && count != 2'd0) begin
                slot0_next = slot1;
                slot1_next = '0;
                count_next = count - 2'd1;
            end
            if (push && count_next != 2'd2) begin
                if (count_next == 2'd0) slot0_next = data;
                else                    slot1_next = data;
                count_next = count_next + 2'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            slot0 <= '0;
            slot1 <= '0;
            count <= 2'd0;
        end else begin
            slot0 <= slot0_next;
            slot1 <= slot1_next;
            count <= count_next;
        end
    end

    assign valid = (count != 2'd0);
    assign head  = slot0;
endmodule

// File: rtl/fetch_unit.sv
// Program counter and instruction-fetch stage of the PUC CPU.
// It handles redirects, halt/resume and PC wrap, and feeds decode through fetch_buffer.
module fetch_unit #(
    parameter int PC_WIDTH          = puc_pkg::PC_WIDTH,
    parameter int INSTRUCTION_WIDTH = puc_pkg::INSTRUCTION_WIDTH,
    parameter int RESET_PC          = puc_pkg::RESET_PC,
    parameter int LAST_PC           = puc_pkg::LAST_PC
) (
    input  logic                         clock,
    input  logic                         reset,
    output logic [PC_WIDTH-1:0]          pc,
    input  logic [INSTRUCTION_WIDTH-1:0] instruction,
    input  logic                         redirect_valid,
    input  logic [PC_WIDTH-1:0]          redirect_pc,
    input  logic                         halt,
    input  logic                         resume,
    output logic                         out_valid,
    output logic [PC_WIDTH-1:0]          out_pc,
    output logic [INSTRUCTION_WIDTH-1:0] out_instruction,
    input  logic                         out_ready,
    output logic                         running
);
    import puc_pkg::*;

    localparam int ENTRY_WIDTH = PC_WIDTH + INSTRUCTION_WIDTH;

    fetch_state_t                 state, state_next;
    logic [PC_WIDTH-1:0]          fetch_pc;
    logic [1:0]                   count;
    logic [ENTRY_WIDTH-1:0]       head;
    logic                         pop, fetch;

    assign pop   = out_valid & out_ready;
    assign fetch = (state == RUN) & ~halt & ~redirect_valid
                 & ((count != 2'd2) | pop);

    always_ff @(posedge clock) begin
        if (reset) state <= RUN;
        else       state <= state_next;
    end

    // A redirect holds the state: a redirect while halted stays halted.
    always_comb begin
        state_next = state;
        if (!redirect_valid) begin
            unique case (state)
                RUN:    if (halt)            state_next = HALTED;
                HALTED: if (resume && !halt) state_next = RUN;
                default:                     state_next = RUN;
            endcase
        end
    end

    always_comb begin
        running = (state == RUN);
    end

    always_ff @(posedge clock) begin
        if (reset)
            fetch_pc <= PC_WIDTH'(RESET_PC);
        else if (redirect_valid)
            fetch_pc <= redirect_pc;
        else if (fetch)
            fetch_pc <= (fetch_pc == PC_WIDTH'(LAST_PC))
                      ? PC_WIDTH'(RESET_PC) : fetch_pc + 1'b1;
    end

    assign pc = fetch_pc;

    fetch_buffer #(
        .WIDTH (ENTRY_WIDTH)
    ) u_buffer (
        .clock (clock),
        .reset (reset),
        .push  (fetch),
        .pop   (pop),
        .flush (redirect_valid),
        .data  ({fetch_pc, instruction}),
        .valid (out_valid),
        .head  (head),
        .count (count)
    );

    assign {out_pc, out_instruction} = head;
endmodule
